// File: rtl/fir_out_requant.sv
// rtl/fir_out_requant.sv - round/shift/saturate of FIR accumulator output into a FWFT stream FIFO
// Optional macro FIR_OUT_WARMUP_EN discards the first TAPS-1 samples after reset.
module fir_out_requant #(
    parameter int TAPS  = 63,
    parameter int SHIFT = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic signed [31:0]         y_in,
    output logic signed [15:0]         m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    input  logic                       clr_ovf,
    output logic                       ovf_sticky,
    output logic [7:0]                 drop_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic signed [32:0] RND =
        (SHIFT > 0) ? (33'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 33'sd0;

    logic                  ena_d_q, ena_d_d;
    logic signed [32:0]    s1_q, s1_d;
    logic                  v1_q, v1_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           lvl_q, lvl_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            drop_q, drop_d;
    logic signed [15:0]    mem [DEPTH];

    logic signed [32:0]    r;
    logic signed [15:0]    sat;
    logic                  sat_hit;
    logic                  warm;
    logic                  push_req;
    logic                  full;
    logic                  pop;
    logic                  do_push;
    logic                  drop_hit;

`ifdef FIR_OUT_WARMUP_EN
    typedef enum logic {WARM, RUN} state_t;
    localparam int CW = $clog2(TAPS + 1);
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign warm = (state_q == WARM);
`else
    assign warm = 1'b0;
`endif

    assign m_valid    = (lvl_q != '0);
    assign m_data     = m_valid ? mem[rd_ptr_q] : 16'sd0;
    assign level      = lvl_q;
    assign ovf_sticky = ovf_q;
    assign drop_cnt   = drop_q;

    always_comb begin
        ena_d_d = ena;
        // 33-bit sum so the rounding constant can never wrap a large positive input
        r    = $signed({y_in[31], y_in}) + RND;
        v1_d = ena_d_q;
        s1_d = ena_d_q ? (r >>> SHIFT) : s1_q;

        sat_hit = 1'b0;
        if (s1_q > 33'sd32767) begin
            sat     = 16'sh7FFF;
            sat_hit = 1'b1;
        end else if (s1_q < -33'sd32768) begin
            sat     = -16'sh8000;
            sat_hit = 1'b1;
        end else begin
            sat = s1_q[15:0];
        end

        push_req = v1_q && !warm;
        full     = (lvl_q == (AW + 1)'(DEPTH));
        pop      = m_valid && m_ready;
        do_push  = push_req && (!full || pop);
        drop_hit = push_req && full && !pop;

        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        lvl_d    = lvl_q;
        if (do_push && !pop) begin
            lvl_d = lvl_q + (AW + 1)'(1);
        end else if (!do_push && pop) begin
            lvl_d = lvl_q - (AW + 1)'(1);
        end

        ovf_d  = clr_ovf ? 1'b0 : (ovf_q || (v1_q && sat_hit));
        drop_d = drop_q;
        if (clr_ovf) begin
            drop_d = 8'd0;
        end else if (drop_hit && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

`ifdef FIR_OUT_WARMUP_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        if (v1_q && warm) begin
            cnt_d = cnt_q + CW'(1);
            if (int'(cnt_d) >= TAPS - 1) begin
                state_d = RUN;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_d_q  <= 1'b0;
            s1_q     <= '0;
            v1_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
`ifdef FIR_OUT_WARMUP_EN
            state_q  <= WARM;
            cnt_q    <= '0;
`endif
        end else begin
            ena_d_q  <= ena_d_d;
            s1_q     <= s1_d;
            v1_q     <= v1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
`ifdef FIR_OUT_WARMUP_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Storage needs no reset: m_data is gated by m_valid, which follows the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= sat;
        end
    end

endmodule

// File: tb/tb_fir_out_requant.sv
// tb/tb_fir_out_requant.sv - directed self-checking bench for fir_out_requant
module tb_fir_out_requant;

    logic               clk;
    logic               rst_n;
    logic               ena;
    logic signed [31:0] y_in;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               clr_ovf;
    logic               ovf_sticky;
    logic [7:0]         drop_cnt;
    logic [3:0]         level;

    int errors;
    int checks;

    fir_out_requant #(.TAPS(63), .SHIFT(8), .DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .y_in       (y_in),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .clr_ovf    (clr_ovf),
        .ovf_sticky (ovf_sticky),
        .drop_cnt   (drop_cnt),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Filter strobe at edge E, y_in valid from just after E.
    task automatic send(input logic signed [31:0] v);
        @(posedge clk); #1;
        ena = 1'b1;
        @(posedge clk); #1;
        ena  = 1'b0;
        y_in = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pop_check(input string tag, input logic signed [15:0] exp);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check(tag, 32'(m_data), 32'(exp));
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic warm_prefix();
`ifdef FIR_OUT_WARMUP_EN
        for (int i = 0; i < 62; i++) send(32'sd0);
        wait_cycles(3);
        check("warm_prefix_level", 32'(level), 32'd0);
`endif
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        ena     = 1'b0;
        y_in    = '0;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        wait_cycles(2);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(ovf_sticky), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        warm_prefix();

        // latency: m_valid high for exactly the cycle after E+2
        m_ready = 1'b1;
        send(32'sd4736);
        check("lat_e0", 32'(m_valid), 32'd0);
        wait_cycles(1);
        check("lat_e1", 32'(m_valid), 32'd0);
        wait_cycles(1);
        check("lat_e2_valid", 32'(m_valid), 32'd1);
        check("lat_e2_data", 32'(m_data), 32'd19);
        wait_cycles(1);
        check("lat_e3", 32'(m_valid), 32'd0);
        m_ready = 1'b0;

        // rounding and hold under backpressure
        send(32'sd384);
        send(-32'sd384);
        send(-32'sd128);
        wait_cycles(3);
        check("rnd_level", 32'(level), 32'd3);
        wait_cycles(2);
        check("hold_data", 32'(m_data), 32'd2);
        pop_check("rnd_384", 16'sd2);
        pop_check("rnd_m384", -16'sd1);
        pop_check("rnd_m128", 16'sd0);
        check("rnd_ovf", 32'(ovf_sticky), 32'd0);

        // saturation and sticky clear
        send(32'sh7FFFFFFF);
        send(32'sh80000000);
        wait_cycles(3);
        check("sat_ovf", 32'(ovf_sticky), 32'd1);
        pop_check("sat_pos", 16'sd32767);
        pop_check("sat_neg", -16'sd32768);
        clr_ovf = 1'b1;
        wait_cycles(1);
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(ovf_sticky), 32'd0);

        // full / drop
        for (int k = 1; k <= 12; k++) send(32'(k * 256));
        wait_cycles(3);
        check("full_level", 32'(level), 32'd8);
        check("full_drop", 32'(drop_cnt), 32'd4);
        check("full_head", 32'(m_data), 32'd1);
        send(32'sd3328);
        wait_cycles(1);
        m_ready = 1'b1;
        wait_cycles(1);
        m_ready = 1'b0;
        check("pushpop_level", 32'(level), 32'd8);
        check("pushpop_drop", 32'(drop_cnt), 32'd4);
        for (int k = 2; k <= 8; k++) pop_check($sformatf("drain_%0d", k), 16'(k));
        pop_check("drain_13", 16'sd13);
        check("drain_level", 32'(level), 32'd0);
        clr_ovf = 1'b1;
        wait_cycles(1);
        clr_ovf = 1'b0;
        check("clr_drop", 32'(drop_cnt), 32'd0);

        // reset mid-stream with samples buffered and in flight
        send(32'sd256);
        send(32'sd512);
        wait_cycles(3);
        send(32'sd768);
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(3);
        check("post_rst_level", 32'(level), 32'd0);
`ifdef FIR_OUT_WARMUP_EN
        for (int i = 1; i <= 62; i++) send(32'(i * 256));
        wait_cycles(3);
        check("warm_discard_level", 32'(level), 32'd0);
        for (int i = 63; i <= 70; i++) send(32'(i * 256));
        wait_cycles(3);
        check("warm_run_level", 32'(level), 32'd8);
        check("warm_first", 32'(m_data), 32'd63);
`else
        send(32'sd1280);
        wait_cycles(3);
        check("post_rst_push_level", 32'(level), 32'd1);
        check("post_rst_push_data", 32'(m_data), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
